mem_burst_ctrl: RTL and testbench

//  Burst front-end for the single-port SRAM memory; sits directly upstream and drives its valid/ready port.

---
 rtl/mem_burst_ctrl.sv | 131 +++++++++++++
 tb/tb_mem_burst_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_ctrl.sv
// rtl/mem_burst_ctrl.sv - burst command front-end driving a word-at-a-time SRAM handshake
// One request in flight at a time; every output decodes from registered state only.
module mem_burst_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64,
  parameter int WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  mem_valid,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE,
    WR_FETCH,
    WR_REQ,
    RD_REQ,
    RD_OUT,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] addr_inc;

  // Bursts run past the top of memory back to location 0.
  assign addr_inc = (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          count_d = cmd_len;
          state_d = cmd_wr ? WR_FETCH : RD_REQ;
        end
      end
      WR_FETCH: begin
        if (wr_valid) begin
          wdata_d = wr_data;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        if (mem_ready) begin
          if (count_q == '0) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_inc;
            count_d = count_q - 1'b1;
            state_d = WR_FETCH;
          end
        end
      end
      RD_REQ: begin
        if (mem_ready) begin
          rdata_d = mem_rdata;
          state_d = RD_OUT;
        end
      end
      RD_OUT: begin
        if (rd_ready) begin
          if (count_q == '0) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_inc;
            count_d = count_q - 1'b1;
            state_d = RD_REQ;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign wr_ready  = (state_q == WR_FETCH);
  assign rd_valid  = (state_q == RD_OUT);
  assign mem_valid = (state_q == WR_REQ) || (state_q == RD_REQ);
  assign mem_wr_en = (state_q == WR_REQ);
  // Address and data buses are forced to zero whenever no request is on them.
  assign mem_addr  = mem_valid ? addr_q : '0;
  assign mem_wdata = mem_wr_en ? wdata_q : '0;
  assign rd_data   = rdata_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb/tb_mem_burst_ctrl.sv - scoreboard bench for mem_burst_ctrl with SRAM and stream models
module tb_mem_burst_ctrl;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int NW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_wr;
  logic [AW-1:0] cmd_addr, cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready;
  logic [DW-1:0] rd_data;
  logic          mem_valid, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ready;
  logic          busy, done;

  mem_burst_ctrl #(.ADDR_WIDTH(AW), .DEPTH(NW), .WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .mem_valid(mem_valid), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  txn_t          exp_txn_q[$];
  logic [DW-1:0] exp_rd_q[$];
  logic [DW-1:0] wr_q[$];
  logic [DW-1:0] ref_mem[NW];
  logic [DW-1:0] mem_model[NW];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int rd_taken_cnt = 0;
  int stall_at = -1;
  int stall_left = 0;
  int mem_lat_max = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Memory-side and stream-side models act on the falling edge; DUT samples them on the rising edge.
  initial begin
    bit            prev_done = 1'b0;
    bit            prev_rd_valid = 1'b0;
    bit            prev_rd_taken = 1'b0;
    logic [DW-1:0] prev_rd_data = '0;
    bit            wr_took = 1'b0;
    int            lat_cnt = 0;
    forever begin
      @(negedge clk);
      if (!mem_valid) chk("idle_bus_zero", {9'd0, mem_wr_en, mem_addr, mem_wdata}, 32'd0);
      if (rd_valid) chk("no_mem_req_in_rd_out", mem_valid, 1'b0);
      if (rd_valid && prev_rd_valid && !prev_rd_taken) chk("rd_data_stable", rd_data, prev_rd_data);
      if (done) begin
        done_cnt++;
        chk("done_one_cycle", prev_done, 1'b0);
      end
      prev_done = done;

      if (mem_valid && !mem_ready) begin
        if (lat_cnt == 0) begin
          mem_ready = 1'b1;
          mem_rdata = mem_model[mem_addr];
          lat_cnt = $urandom_range(0, mem_lat_max);
        end else begin
          lat_cnt--;
        end
      end else begin
        mem_ready = !mem_valid && ($urandom_range(0, 7) == 0);
        mem_rdata = DW'($urandom);
      end

      if (wr_took && wr_q.size() > 0) void'(wr_q.pop_front());
      wr_valid = (wr_q.size() > 0) && ($urandom_range(0, 3) != 0);
      wr_data  = wr_valid ? wr_q[0] : DW'($urandom);
      wr_took  = wr_valid && wr_ready && rst_n;

      if (rd_valid && stall_left > 0 && rd_taken_cnt == stall_at) begin
        rd_ready = 1'b0;
        stall_left--;
      end else begin
        rd_ready = ($urandom_range(0, 3) != 0);
      end
      prev_rd_valid = rd_valid;
      prev_rd_data  = rd_data;
      prev_rd_taken = rd_valid && rd_ready;
    end
  end

  // Completion monitor: memory transactions and read-stream beats against the expected queues.
  initial begin
    txn_t t;
    logic [DW-1:0] e;
    forever begin
      @(posedge clk);
      if (rst_n && mem_valid && mem_ready) begin
        if (mem_wr_en) mem_model[mem_addr] = mem_wdata;
        if (exp_txn_q.size() == 0) begin
          chk("txn_unexpected", exp_txn_q.size(), 1);
        end else begin
          t = exp_txn_q.pop_front();
          chk("txn_wr_en", mem_wr_en, t.wr);
          chk("txn_addr", mem_addr, t.addr);
          if (t.wr) chk("txn_wdata", mem_wdata, t.data);
        end
      end
      if (rst_n && rd_valid && rd_ready) begin
        if (exp_rd_q.size() == 0) begin
          chk("rd_unexpected", exp_rd_q.size(), 1);
        end else begin
          e = exp_rd_q.pop_front();
          chk("rd_data", rd_data, e);
        end
        rd_taken_cnt++;
      end
    end
  end

  task automatic drive_cmd(input bit wr, input int addr, input int len);
    int waited = 0;
    bit last_done = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = AW'(addr);
    cmd_len   = AW'(len);
    while (!cmd_ready && waited < 3000) begin
      last_done = done;
      @(negedge clk);
      waited++;
    end
    chk("cmd_accept", cmd_ready, 1'b1);
    if (waited > 0) chk("accept_first_idle", last_done, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_wr    = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_len   = AW'($urandom);
    chk("busy_after_accept", busy, 1'b1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("burst_complete", busy, 1'b0);
    chk("done_count", done_cnt, exp_done);
  endtask

  task automatic burst(input bit wr, input int addr, input int len, input int pat,
                       input bit wait_end, input bit count_done);
    int a;
    logic [DW-1:0] d;
    for (int i = 0; i <= len; i++) begin
      a = (addr + i) % NW;
      if (wr) begin
        d = (pat < 0) ? DW'($urandom) : DW'(pat + i);
        ref_mem[a] = d;
        exp_txn_q.push_back('{1'b1, AW'(a), d});
        wr_q.push_back(d);
      end else begin
        exp_txn_q.push_back('{1'b0, AW'(a), '0});
        exp_rd_q.push_back(ref_mem[a]);
      end
    end
    if (count_done) exp_done++;
    drive_cmd(wr, addr, len);
    if (wait_end) wait_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    chk({tag, "_wr_ready"}, wr_ready, 1'b0);
    chk({tag, "_rd_valid"}, rd_valid, 1'b0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_mem_bus"}, {mem_valid, mem_wr_en, mem_addr, mem_wdata}, 0);
    chk({tag, "_busy_done"}, {busy, done}, 0);
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs(tag);
    exp_txn_q.delete();
    exp_rd_q.delete();
    wr_q.delete();
    stall_left = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    int base, n, bad;
    for (int i = 0; i < NW; i++) begin
      ref_mem[i]   = '0;
      mem_model[i] = '0;
    end
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_init");
    rst_n = 1'b1;

    // Park the controller in WR_FETCH with no data, then reset mid-cycle.
    drive_cmd(1'b1, 5, 2);
    repeat (2) @(negedge clk);
    chk("parked_wr_ready", wr_ready, 1'b1);
    async_reset("async_reset");
    repeat (2) @(negedge clk);
    chk("no_done_after_reset", done_cnt, exp_done);

    mem_lat_max = 0;
    burst(1'b1, 0, 3, 'hA000, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) chk("mem_after_write", mem_model[i], 32'hA000 + i);

    stall_at = rd_taken_cnt + 1;
    stall_left = 3;
    burst(1'b0, 0, 3, -1, 1'b1, 1'b1);
    chk("stall_applied", stall_left, 0);

    burst(1'b1, 62, 3, -1, 1'b1, 1'b1);
    burst(1'b0, 62, 3, -1, 1'b1, 1'b1);

    burst(1'b1, 10, 5, -1, 1'b0, 1'b1);
    burst(1'b0, 10, 5, -1, 1'b1, 1'b1);

    base = rd_taken_cnt;
    burst(1'b0, 0, 3, -1, 1'b0, 1'b0);
    n = 0;
    while (rd_taken_cnt < base + 1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("first_word_taken", rd_taken_cnt, base + 1);
    async_reset("reset_mid_burst");
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_cnt, exp_done);
    burst(1'b0, 1, 0, -1, 1'b1, 1'b1);

    mem_lat_max = 2;
    repeat (25) begin
      burst(1'($urandom), $urandom_range(0, NW - 1),
            ($urandom_range(0, 9) == 0) ? NW - 1 : $urandom_range(0, 7), -1, 1'b1, 1'b1);
    end

    repeat (4) @(negedge clk);
    chk("txn_queue_drained", exp_txn_q.size(), 0);
    chk("rd_queue_drained", exp_rd_q.size(), 0);
    chk("wr_stream_drained", wr_q.size(), 0);
    chk("final_done_count", done_cnt, exp_done);
    bad = 0;
    for (int i = 0; i < NW; i++) if (mem_model[i] !== ref_mem[i]) bad++;
    chk("final_mem_image", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
